// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and hazard scoreboard for the RV32I pipeline: tracks in-flight
// destination registers per backend stage and resolves forwarding and stalls for the ID operands.
module fwd_hazard_scoreboard #(
    parameter int NB_OPERAND = 5,
    parameter int N_SRC      = 2,
    parameter int N_STAGES   = 3,
    parameter int NB_SEL     = $clog2(N_STAGES + 1),
    parameter int NB_CNT     = 32
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_advance,
    input  logic                        i_flush,
    input  logic                        i_id_valid,
    input  logic [N_SRC*NB_OPERAND-1:0] i_id_rs,
    input  logic [N_SRC-1:0]            i_id_rs_used,
    input  logic                        i_id_rf_write,
    input  logic [NB_OPERAND-1:0]       i_id_rd,
    input  logic [NB_SEL-1:0]           i_id_ready_stage,
    output logic [N_SRC*NB_SEL-1:0]     o_fwd_sel,
    output logic                        o_stall,
    output logic [NB_CNT-1:0]           o_stall_count
);

    // Entry index 0 holds stage 1 (EX); index k holds stage k+1.
    logic [N_STAGES-1:0]   valid_q, valid_d;
    logic [NB_OPERAND-1:0] rd_q  [N_STAGES];
    logic [NB_OPERAND-1:0] rd_d  [N_STAGES];
    logic [NB_SEL-1:0]     rdy_q [N_STAGES];
    logic [NB_SEL-1:0]     rdy_d [N_STAGES];
    logic [NB_CNT-1:0]     cnt_q, cnt_d;

    logic [N_SRC*NB_SEL-1:0] fwd_sel_s;
    logic [N_SRC-1:0]        haz_s;
    logic                    stall_s;
    logic                    ins_s;
    logic [NB_SEL-1:0]       ins_rdy_s;

    // Clamp the incoming ready stage into the legal 1..N_STAGES range.
    always_comb begin
        ins_rdy_s = i_id_ready_stage;
        if (i_id_ready_stage == {NB_SEL{1'b0}}) begin
            ins_rdy_s = NB_SEL'(1);
        end else if (i_id_ready_stage > NB_SEL'(N_STAGES)) begin
            ins_rdy_s = NB_SEL'(N_STAGES);
        end else begin
            ins_rdy_s = i_id_ready_stage;
        end
    end

    // Operand match: scan oldest to youngest so the youngest match overrides.
    always_comb begin
        logic hit;
        logic rdy;
        fwd_sel_s = '0;
        haz_s     = '0;
        hit       = 1'b0;
        rdy       = 1'b0;
        for (int j = 0; j < N_SRC; j++) begin
            for (int k = N_STAGES - 1; k >= 0; k--) begin
                hit = valid_q[k] && (rd_q[k] != {NB_OPERAND{1'b0}}) &&
                      (rd_q[k] == i_id_rs[j*NB_OPERAND +: NB_OPERAND]) &&
                      i_id_rs_used[j];
                rdy = (NB_SEL'(k + 1) >= rdy_q[k]);
                fwd_sel_s[j*NB_SEL +: NB_SEL] = hit ? (rdy ? NB_SEL'(k + 1) : {NB_SEL{1'b0}})
                                                    : fwd_sel_s[j*NB_SEL +: NB_SEL];
                haz_s[j] = hit ? ~rdy : haz_s[j];
            end
        end
        stall_s = i_id_valid & (|haz_s);
        ins_s   = i_id_valid & i_id_rf_write & ~stall_s & (i_id_rd != {NB_OPERAND{1'b0}});
    end

    // Next entry state and saturating stall counter.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        rdy_d   = rdy_q;
        if (i_flush) begin
            valid_d = {N_STAGES{1'b0}};
        end else if (i_advance) begin
            for (int k = 1; k < N_STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                rd_d[k]    = rd_q[k-1];
                rdy_d[k]   = rdy_q[k-1];
            end
            valid_d[0] = ins_s;
            rd_d[0]    = i_id_rd;
            rdy_d[0]   = ins_rdy_s;
        end else begin
            valid_d = valid_q;
        end

        if (stall_s && !i_flush && (cnt_q != {NB_CNT{1'b1}})) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid_q <= {N_STAGES{1'b0}};
            cnt_q   <= {NB_CNT{1'b0}};
            for (int k = 0; k < N_STAGES; k++) begin
                rd_q[k]  <= {NB_OPERAND{1'b0}};
                rdy_q[k] <= {NB_SEL{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            rdy_q   <= rdy_d;
        end
    end

    assign o_fwd_sel     = fwd_sel_s;
    assign o_stall       = stall_s;
    assign o_stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench: per-cycle comparison against a list-based pipeline model,
// plus directed scenarios with hand-computed expectations.
module tb_fwd_hazard_scoreboard;

    localparam int NB_OPERAND = 5;
    localparam int N_SRC      = 2;
    localparam int N_STAGES   = 3;
    localparam int NB_SEL     = 2;
    localparam int NB_CNT     = 2;
    localparam int CNT_MAX    = 3;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        adv;
    logic                        flush;
    logic                        id_valid;
    logic [N_SRC*NB_OPERAND-1:0] id_rs;
    logic [N_SRC-1:0]            used;
    logic                        id_wr;
    logic [NB_OPERAND-1:0]       id_rd;
    logic [NB_SEL-1:0]           id_rdy;
    logic [N_SRC*NB_SEL-1:0]     fwd_sel;
    logic                        stall;
    logic [NB_CNT-1:0]           cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit check_en  = 1'b0;

    // Model: stage k (1 = youngest) holds valid / rd / ready stage.
    bit m_valid [1:N_STAGES];
    int m_rd    [1:N_STAGES];
    int m_rdy   [1:N_STAGES];
    int m_cnt   = 0;

    always #5 clk = ~clk;

    fwd_hazard_scoreboard #(
        .NB_OPERAND(NB_OPERAND), .N_SRC(N_SRC), .N_STAGES(N_STAGES),
        .NB_SEL(NB_SEL), .NB_CNT(NB_CNT)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_advance(adv), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rs_used(used),
        .i_id_rf_write(id_wr), .i_id_rd(id_rd), .i_id_ready_stage(id_rdy),
        .o_fwd_sel(fwd_sel), .o_stall(stall), .o_stall_count(cnt)
    );

    function automatic void model_eval(output logic [N_SRC*NB_SEL-1:0] sel, output logic st);
        logic haz;
        int   rs;
        haz = 1'b0;
        sel = '0;
        for (int j = 0; j < N_SRC; j++) begin
            rs = int'(id_rs[j*NB_OPERAND +: NB_OPERAND]);
            for (int k = 1; k <= N_STAGES; k++) begin
                if (m_valid[k] && m_rd[k] != 0 && m_rd[k] == rs && used[j]) begin
                    if (k >= m_rdy[k]) sel[j*NB_SEL +: NB_SEL] = NB_SEL'(k);
                    else haz = 1'b1;
                    break;
                end
            end
        end
        st = id_valid && haz;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model state update on each rising edge.
    initial begin
        logic [N_SRC*NB_SEL-1:0] s;
        logic st;
        int r;
        forever begin
            @(posedge clk);
            model_eval(s, st);
            if (rst) begin
                for (int k = 1; k <= N_STAGES; k++) m_valid[k] = 1'b0;
                m_cnt = 0;
            end else begin
                if (st && !flush && m_cnt < CNT_MAX) m_cnt++;
                if (flush) begin
                    for (int k = 1; k <= N_STAGES; k++) m_valid[k] = 1'b0;
                end else if (adv) begin
                    for (int k = N_STAGES; k >= 2; k--) begin
                        m_valid[k] = m_valid[k-1];
                        m_rd[k]    = m_rd[k-1];
                        m_rdy[k]   = m_rdy[k-1];
                    end
                    r = int'(id_rdy);
                    m_valid[1] = id_valid && id_wr && !st && (id_rd != 0);
                    m_rd[1]    = int'(id_rd);
                    m_rdy[1]   = (r == 0) ? 1 : ((r > N_STAGES) ? N_STAGES : r);
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        logic [N_SRC*NB_SEL-1:0] es;
        logic est;
        forever begin
            @(negedge clk);
            if (check_en) begin
                model_eval(es, est);
                check("model_sel",   int'(fwd_sel), int'(es));
                check("model_stall", int'(stall),   int'(est));
                check("model_cnt",   int'(cnt),     m_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input bit wr, input int rd, input int rdy,
                          input int rs0, input int rs1, input logic [1:0] u);
        id_valid = v;
        id_wr    = wr;
        id_rd    = NB_OPERAND'(rd);
        id_rdy   = NB_SEL'(rdy);
        id_rs    = {NB_OPERAND'(rs1), NB_OPERAND'(rs0)};
        used     = u;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_id(1'b0, 1'b0, 0, 0, 0, 0, 2'b00);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        adv   = 1'b1;
        flush = 1'b0;
        do_reset();
        check_en = 1'b1;
        check("rst_sel",   int'(fwd_sel), 0);
        check("rst_stall", int'(stall),   0);
        check("rst_cnt",   int'(cnt),     0);

        // Forward from EX, and ready stage 0 clamped to 1
        set_id(1'b1, 1'b1, 5, 1, 0, 0, 2'b00);
        tick();
        set_id(1'b1, 1'b1, 6, 0, 5, 0, 2'b01);
        #1;
        check("ex_fwd_sel",   int'(fwd_sel), 1);
        check("ex_fwd_stall", int'(stall),   0);
        tick();
        set_id(1'b1, 1'b0, 0, 0, 6, 5, 2'b11);
        #1;
        check("rdy0_clamp_sel", int'(fwd_sel), 9);
        tick();

        // Load-use
        do_reset();
        set_id(1'b1, 1'b1, 7, 2, 0, 0, 2'b00);
        tick();
        set_id(1'b1, 1'b0, 0, 0, 0, 7, 2'b10);
        #1;
        check("lu_stall", int'(stall),   1);
        check("lu_sel",   int'(fwd_sel), 0);
        tick();
        #1;
        check("lu_sel2",   int'(fwd_sel), 8);
        check("lu_stall2", int'(stall),   0);
        check("lu_cnt",    int'(cnt),     1);
        tick();

        // Youngest wins
        do_reset();
        set_id(1'b1, 1'b1, 3, 1, 0, 0, 2'b00); tick();
        set_id(1'b1, 1'b1, 9, 1, 0, 0, 2'b00); tick();
        set_id(1'b1, 1'b1, 3, 1, 0, 0, 2'b00); tick();
        set_id(1'b1, 1'b0, 0, 0, 3, 3, 2'b11);
        #1;
        check("youngest_sel", int'(fwd_sel), 5);
        tick();

        // x0 and unused sources
        do_reset();
        set_id(1'b1, 1'b1, 0, 1, 0, 0, 2'b00); tick();
        set_id(1'b1, 1'b1, 4, 1, 0, 0, 2'b00); tick();
        set_id(1'b1, 1'b0, 0, 0, 0, 4, 2'b01);
        #1;
        check("x0_unused_sel",   int'(fwd_sel), 0);
        check("x0_unused_stall", int'(stall),   0);
        set_id(1'b1, 1'b0, 0, 0, 0, 4, 2'b11);
        #1;
        check("used_sel", int'(fwd_sel), 4);
        tick();

        // Hold then flush with advance
        do_reset();
        set_id(1'b1, 1'b1, 10, 1, 0, 0, 2'b00); tick();
        set_id(1'b1, 1'b1, 11, 1, 0, 0, 2'b00); tick();
        set_id(1'b1, 1'b1, 12, 1, 0, 0, 2'b00); tick();
        set_id(1'b1, 1'b0, 0, 0, 10, 11, 2'b11);
        adv = 1'b0;
        #1;
        check("hold_sel0", int'(fwd_sel), 11);
        tick(); #1;
        check("hold_sel1", int'(fwd_sel), 11);
        tick(); #1;
        check("hold_sel2", int'(fwd_sel), 11);
        adv   = 1'b1;
        flush = 1'b1;
        set_id(1'b1, 1'b1, 13, 1, 10, 11, 2'b11);
        tick();
        flush = 1'b0;
        set_id(1'b1, 1'b0, 0, 0, 13, 12, 2'b11);
        #1;
        check("flush_sel",   int'(fwd_sel), 0);
        check("flush_stall", int'(stall),   0);
        tick();

        // Stall coinciding with flush is not counted
        do_reset();
        set_id(1'b1, 1'b1, 8, 2, 0, 0, 2'b00); tick();
        set_id(1'b1, 1'b0, 0, 0, 8, 0, 2'b01);
        #1;
        check("fl_stall", int'(stall), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("fl_cnt",    int'(cnt),   0);
        check("fl_stall2", int'(stall), 0);

        // Stall under hold, saturation, reset mid-stall
        do_reset();
        set_id(1'b1, 1'b1, 8, 3, 0, 0, 2'b00); tick();
        set_id(1'b1, 1'b0, 0, 0, 8, 0, 2'b01);
        adv = 1'b0;
        tick(); tick(); #1;
        check("hold_stall", int'(stall), 1);
        check("hold_cnt",   int'(cnt),   2);
        adv = 1'b1;
        tick(); tick(); #1;
        check("sat_cnt",   int'(cnt),     3);
        check("sat_stall", int'(stall),   0);
        check("sat_sel",   int'(fwd_sel), 3);
        set_id(1'b1, 1'b1, 9, 3, 0, 0, 2'b00); tick();
        set_id(1'b1, 1'b0, 0, 0, 9, 0, 2'b01);
        tick(); #1;
        check("sat_hold_cnt", int'(cnt),   3);
        check("sat_stall2",   int'(stall), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_cnt",   int'(cnt),     0);
        check("rst_mid_stall", int'(stall),   0);
        check("rst_mid_sel",   int'(fwd_sel), 0);

        set_id(1'b0, 1'b0, 0, 0, 0, 0, 2'b00);
        tick();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the RV32I pipeline.
- Tracks destination registers of in-flight instructions in an internal shift register, one entry per backend stage (stage 1 = EX, up to N_STAGES, default 3 = EX/MEM/WB).
- For each source operand of the instruction in ID, computes the forwarding source.
- Raises a stall when the producing stage has not yet produced the result (load-use, multi-cycle ops).
- Keeps a saturating stall-cycle performance counter.

Parameters:
- NB_OPERAND, 5, register index width.
- N_SRC, 2, number of source operands checked per ID instruction.
- N_STAGES, 3, number of tracked backend stages.
- NB_SEL, $clog2(N_STAGES+1), forward-select width (derived).
- NB_CNT, 32, stall counter width.

Ports:
- i_clock  in  1  clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_advance  in  1  backend advances this cycle; 0 = hold all entries.
- i_flush  in  1  squash all in-flight entries (branch/trap).
- i_id_valid  in  1  valid instruction in ID.
- i_id_rs  in  N_SRC*NB_OPERAND  source register indices; source j at bits [j*NB_OPERAND +: NB_OPERAND].
- i_id_rs_used  in  N_SRC  source j is actually read.
- i_id_rf_write  in  1  ID instruction writes rd.
- i_id_rd  in  NB_OPERAND  ID destination register.
- i_id_ready_stage  in  NB_SEL  first stage (1..N_STAGES) at which the result is forwardable. ALU=1, load=2.
- o_fwd_sel  out  N_SRC*NB_SEL  per-source select: 0 = register file, k = forward from stage k.
- o_stall  out  1  hold ID/IF and insert a bubble.
- o_stall_count  out  NB_CNT  cycles with o_stall=1.

Behaviour:
- Entry state, per stage k: valid, rd, ready_stage.
- Reset: all entries invalid; o_stall_count=0. Consequently o_fwd_sel=0 and o_stall=0.
- Outputs o_fwd_sel and o_stall are combinational from the registered entries and the ID inputs (0-cycle latency).
- Entry match for source j: entry k matches when all of the following hold:
  - valid;
  - rd != 0;
  - rd == rs_j;
  - i_id_rs_used[j] = 1.
  - x0 never matches.
- Priority: the youngest matching entry (lowest k) determines the result; older matches are ignored.
- Ready youngest match (k >= ready_stage): o_fwd_sel[j] = k.
- Not-ready youngest match (k < ready_stage): o_fwd_sel[j] = 0 and the source is hazarded.
- No match: o_fwd_sel[j] = 0.
- o_stall = i_id_valid AND (any source hazarded). With i_id_valid=0, o_stall=0.
- Entry update at posedge, in priority order:
  1. i_reset;
  2. i_flush: all entries invalid;
  3. i_advance=0: hold all entries;
  4. i_advance=1: entry[k] <= entry[k-1] for k >= 2; the entry beyond N_STAGES is dropped.
- New entry[1] on advance:
  - If i_id_valid && i_id_rf_write && !o_stall && i_id_rd != 0: valid, i_id_rd, i_id_ready_stage.
  - Otherwise: invalid (bubble).
- i_id_ready_stage of 0 is treated as 1. Values > N_STAGES are treated as N_STAGES.
- Stall counter:
  - increments by 1 each cycle o_stall=1, unless i_reset or i_flush is high that cycle;
  - saturates at all-ones (no wrap).
- Flush and advance together: flush wins; the ID instruction is not inserted.
- Reset mid-operation: all state cleared next cycle regardless of other inputs.
- A stall while i_advance=0: entries hold, so the stall persists until the backend advances.

Test Plan:
- Forward from EX: ALU op, rd=5, ready_stage=1, issued and advanced. Next ID has rs1=5 used -> o_fwd_sel[0]=1, o_stall=0.
- Load-use: load rd=7, ready_stage=2 in stage 1; ID rs2=7.
  - Cycle 1 -> o_stall=1, o_fwd_sel[1]=0; bubble enters stage 1.
  - Cycle 2 -> o_fwd_sel[1]=2, o_stall=0.
  - o_stall_count=1.
- Youngest wins: rd=3 in stage 3 and rd=3 in stage 1 (both ready), ID rs1=rs2=3 -> both sels = 1.
- x0 and unused sources: entry rd=0 written, ID rs1=0 -> sel 0. Matching rs2 with i_id_rs_used[1]=0 -> sel 0, no stall.
- Flush/hold: 3 entries loaded, i_advance=0 for 2 cycles -> sels unchanged. Then i_flush=1 with i_advance=1 -> all sels 0, stall 0, no new entry.
- Reset/saturation: with NB_CNT=2, force 5 stall cycles -> count 3 (saturated). Assert i_reset mid-stall -> count 0, all entries invalid next cycle.
